// File: rtl/ob_match_ctrl.sv
// ob_match_ctrl: crosses bid/ask table heads into trades and drains both reject slots round-robin.
// Optional macro OB_MATCH_STATS_EN adds saturating trade_cnt_r / volume_cnt_r outputs.
package ob_match_pkg;
    typedef struct packed {
        logic [15:0] uid;
        logic [15:0] price;
        logic [15:0] qty;
    } table_t;
    typedef struct packed {
        logic [15:0] bid_uid;
        logic [15:0] ask_uid;
        logic [15:0] price;
        logic [15:0] qty;
    } trade_t;
endpackage

module ob_match_ctrl
    import ob_match_pkg::*;
#(
    parameter int STATS_W = 32
) (
`ifdef OB_MATCH_STATS_EN
    output logic [STATS_W-1:0] trade_cnt_r,
    output logic [STATS_W-1:0] volume_cnt_r,
`endif
    input  logic   clk,
    input  logic   rst,
    input  logic   match_en,
    input  logic   hold,
    input  logic   bid_head_vld_r,
    input  table_t bid_head_r,
    output logic   bid_head_pop,
    output logic   bid_head_upt,
    output table_t bid_head_upt_tbl,
    input  logic   ask_head_vld_r,
    input  table_t ask_head_r,
    output logic   ask_head_pop,
    output logic   ask_head_upt,
    output table_t ask_head_upt_tbl,
    input  logic   bid_reject_vld_r,
    input  table_t bid_reject_r,
    output logic   bid_reject_pop,
    input  logic   ask_reject_vld_r,
    input  table_t ask_reject_r,
    output logic   ask_reject_pop,
    output logic   trade_vld_r,
    output trade_t trade_r,
    input  logic   trade_accept,
    output logic   rej_vld_r,
    output table_t rej_r,
    output logic   rej_is_ask_r,
    input  logic   rej_accept,
    output logic   busy_r
);
    typedef enum logic [1:0] {IDLE, MATCH, SETTLE} state_t;
    state_t      r_state, w_next;
    logic [15:0] w_q;
    logic        w_start, w_rej_free, w_bid_el, w_ask_el, w_bid_gnt, w_ask_gnt;
    logic        r_bid_rpop, r_ask_rpop, r_rr_ask;
    // Packed BCD digits order the same as their binary value, so a plain compare suffices.
    assign w_q     = (bid_head_r.qty < ask_head_r.qty) ? bid_head_r.qty : ask_head_r.qty;
    assign w_start = match_en & ~hold & bid_head_vld_r & ask_head_vld_r &
                     (bid_head_r.price >= ask_head_r.price) & (~trade_vld_r | trade_accept);
    assign busy_r  = (r_state != IDLE);
    always_comb begin
        w_next           = r_state;
        bid_head_pop     = 1'b0;
        bid_head_upt     = 1'b0;
        bid_head_upt_tbl = '0;
        ask_head_pop     = 1'b0;
        ask_head_upt     = 1'b0;
        ask_head_upt_tbl = '0;
        case (r_state)
            IDLE:  w_next = w_start ? MATCH : IDLE;
            MATCH: begin
                w_next           = SETTLE;
                bid_head_pop     = (bid_head_r.qty == w_q);
                bid_head_upt     = (bid_head_r.qty != w_q);
                bid_head_upt_tbl = bid_head_upt ? {bid_head_r.uid, bid_head_r.price, bid_head_r.qty - w_q} : '0;
                ask_head_pop     = (ask_head_r.qty == w_q);
                ask_head_upt     = (ask_head_r.qty != w_q);
                ask_head_upt_tbl = ask_head_upt ? {ask_head_r.uid, ask_head_r.price, ask_head_r.qty - w_q} : '0;
            end
            default: w_next = IDLE;
        endcase
    end
    // A side popped last cycle still shows its old reject_vld_r, so it sits out one cycle.
    assign w_rej_free     = ~rej_vld_r | rej_accept;
    assign w_bid_el       = bid_reject_vld_r & ~r_bid_rpop;
    assign w_ask_el       = ask_reject_vld_r & ~r_ask_rpop;
    assign w_bid_gnt      = ~rst & w_rej_free & w_bid_el & (~w_ask_el | ~r_rr_ask);
    assign w_ask_gnt      = ~rst & w_rej_free & w_ask_el & ~w_bid_gnt;
    assign bid_reject_pop = w_bid_gnt;
    assign ask_reject_pop = w_ask_gnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            trade_vld_r  <= 1'b0;
            trade_r      <= '0;
            rej_vld_r    <= 1'b0;
            rej_r        <= '0;
            rej_is_ask_r <= 1'b0;
            r_bid_rpop   <= 1'b0;
            r_ask_rpop   <= 1'b0;
            r_rr_ask     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_bid_rpop <= w_bid_gnt;
            r_ask_rpop <= w_ask_gnt;
            if (r_state == MATCH) begin
                trade_vld_r <= 1'b1;
                trade_r     <= {bid_head_r.uid, ask_head_r.uid, ask_head_r.price, w_q};
            end else if (trade_accept) begin
                trade_vld_r <= 1'b0;
            end
            if (w_bid_gnt | w_ask_gnt) begin
                rej_vld_r    <= 1'b1;
                rej_r        <= w_bid_gnt ? bid_reject_r : ask_reject_r;
                rej_is_ask_r <= w_ask_gnt;
                r_rr_ask     <= w_bid_gnt;
            end else if (rej_accept) begin
                rej_vld_r <= 1'b0;
            end
        end
    end
`ifdef OB_MATCH_STATS_EN
    localparam int SW1 = STATS_W + 1;
    logic [STATS_W:0] w_vol_sum;
    assign w_vol_sum = {1'b0, volume_cnt_r} + SW1'(w_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            trade_cnt_r  <= '0;
            volume_cnt_r <= '0;
        end else if (r_state == MATCH) begin
            trade_cnt_r  <= (&trade_cnt_r) ? trade_cnt_r : trade_cnt_r + 1'b1;
            volume_cnt_r <= w_vol_sum[STATS_W] ? '1 : w_vol_sum[STATS_W-1:0];
        end
    end
`endif
endmodule
